// File: rtl/vending_pkg.sv
// Shared vending definitions: change codes, dispenser FSM encoding and the
// change-code to coin-count lookup.
package vending_pkg;

    localparam logic [2:0] CODE_NONE   = 3'b000;
    localparam logic [2:0] NICKEL      = 3'b001;
    localparam logic [2:0] DIME        = 3'b010;
    localparam logic [2:0] NICKEL_DIME = 3'b011;
    localparam logic [2:0] DIMES_2     = 3'b100;
    localparam logic [2:0] QUARTER     = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT
    } disp_state_t;

    // Wide enough to hold a nickel count after a dime-to-two-nickels conversion.
    typedef logic [2:0] coin_cnt_t;

    typedef struct packed {
        coin_cnt_t nickels;
        coin_cnt_t dimes;
    } coin_count_t;

    function automatic logic code_valid(input logic [2:0] code);
        return (code >= NICKEL) && (code <= DIMES_2);
    endfunction

    function automatic coin_count_t coin_count(input logic [2:0] code);
        coin_count_t cnt;
        cnt.nickels = 3'd0;
        cnt.dimes   = 3'd0;
        case (code)
            NICKEL:      cnt.nickels = 3'd1;
            DIME:        cnt.dimes   = 3'd1;
            NICKEL_DIME: begin
                cnt.nickels = 3'd1;
                cnt.dimes   = 3'd1;
            end
            DIMES_2:     cnt.dimes   = 3'd2;
            default:     ;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/change_fifo.sv
// Synchronous FIFO for pending change codes; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module change_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge Clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/change_dispenser.sv
// Change payout stage: queues change codes from the vending FSM and drives the
// nickel/dime hoppers one coin at a time, tracking inventory and fault flags.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT      = 16,
    parameter int INV_W        = 8,
    parameter int INIT_NICKELS = 20,
    parameter int INIT_DIMES   = 20
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [2:0] change_in,
    input  logic       vend_in,
    input  logic       refill,
    input  logic       nickel_ack,
    input  logic       dime_ack,
    output logic       nickel_req,
    output logic       dime_req,
    output logic       dispense_item,
    output logic       busy,
    output logic       nickel_empty,
    output logic       dime_empty,
    output logic       short_change,
    output logic       overflow,
    output logic       fault
);

    localparam int TM_W = $clog2(TIMEOUT) + 1;

    disp_state_t      r_state;
    disp_state_t      w_next_state;
    logic [2:0]       w_fifo_data;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_code_valid;
    coin_count_t      w_cnt;
    coin_cnt_t        r_n_cnt;
    coin_cnt_t        r_d_cnt;
    logic [INV_W-1:0] r_nickel_inv;
    logic [INV_W-1:0] r_dime_inv;
    logic [TM_W-1:0]  r_timer;
    logic             r_nickel_req;
    logic             r_dime_req;
    logic             r_vend_q;
    logic             r_dispense;
    logic             r_short;
    logic             r_overflow;
    logic             r_fault;

    logic w_pop;
    logic w_issue_n;
    logic w_issue_d;
    logic w_short_n;
    logic w_short_d;
    logic w_convert;
    logic w_paid_n;
    logic w_paid_d;
    logic w_timeout;

    assign w_code_valid = code_valid(change_in);
    assign w_cnt        = coin_count(w_fifo_data);

    change_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (3)
    ) u_fifo (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .i_push  (w_code_valid),
        .i_data  (change_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_issue_n    = 1'b0;
        w_issue_d    = 1'b0;
        w_short_n    = 1'b0;
        w_short_d    = 1'b0;
        w_convert    = 1'b0;
        w_paid_n     = 1'b0;
        w_paid_d     = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) w_next_state = ST_LOAD;
            end
            ST_LOAD: begin
                w_pop        = 1'b1;
                w_next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (r_n_cnt != '0) begin
                    if (r_nickel_inv != '0) begin
                        w_issue_n    = 1'b1;
                        w_next_state = ST_WAIT;
                    end else begin
                        w_short_n = 1'b1;
                    end
                end else if (r_d_cnt != '0) begin
                    if (r_dime_inv != '0) begin
                        w_issue_d    = 1'b1;
                        w_next_state = ST_WAIT;
                    end else if (r_nickel_inv >= INV_W'(2)) begin
                        w_convert = 1'b1;
                    end else begin
                        w_short_d = 1'b1;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_nickel_req && nickel_ack) begin
                    w_paid_n     = 1'b1;
                    w_next_state = ST_ISSUE;
                end else if (r_dime_req && dime_ack) begin
                    w_paid_d     = 1'b1;
                    w_next_state = ST_ISSUE;
                end else if (r_timer == TM_W'(TIMEOUT - 1)) begin
                    w_timeout    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Coin down-counters and hopper requests; a timeout abandons the entry.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_n_cnt      <= '0;
            r_d_cnt      <= '0;
            r_nickel_req <= 1'b0;
            r_dime_req   <= 1'b0;
            r_timer      <= '0;
        end else begin
            if (w_pop)                      r_n_cnt <= w_cnt.nickels;
            else if (w_short_n || w_paid_n) r_n_cnt <= r_n_cnt - 3'd1;
            else if (w_convert)             r_n_cnt <= r_n_cnt + 3'd2;
            else if (w_timeout)             r_n_cnt <= '0;

            if (w_pop)                                  r_d_cnt <= w_cnt.dimes;
            else if (w_short_d || w_paid_d || w_convert) r_d_cnt <= r_d_cnt - 3'd1;
            else if (w_timeout)                         r_d_cnt <= '0;

            if (w_issue_n)                  r_nickel_req <= 1'b1;
            else if (w_paid_n || w_timeout) r_nickel_req <= 1'b0;

            if (w_issue_d)                  r_dime_req <= 1'b1;
            else if (w_paid_d || w_timeout) r_dime_req <= 1'b0;

            if (r_state == ST_WAIT) r_timer <= r_timer + TM_W'(1);
            else                    r_timer <= '0;
        end
    end

    // Inventory, sticky flags and the vend edge detector.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_nickel_inv <= INV_W'(INIT_NICKELS);
            r_dime_inv   <= INV_W'(INIT_DIMES);
            r_short      <= 1'b0;
            r_overflow   <= 1'b0;
            r_fault      <= 1'b0;
            r_vend_q     <= 1'b0;
            r_dispense   <= 1'b0;
        end else begin
            if (refill)                              r_nickel_inv <= INV_W'(INIT_NICKELS);
            else if (w_paid_n && r_nickel_inv != '0) r_nickel_inv <= r_nickel_inv - INV_W'(1);

            if (refill)                            r_dime_inv <= INV_W'(INIT_DIMES);
            else if (w_paid_d && r_dime_inv != '0) r_dime_inv <= r_dime_inv - INV_W'(1);

            if (w_short_n || w_short_d)                   r_short    <= 1'b1;
            if (w_code_valid && w_fifo_full && !w_pop)    r_overflow <= 1'b1;
            if (w_timeout)                                r_fault    <= 1'b1;

            r_vend_q   <= vend_in;
            r_dispense <= vend_in && !r_vend_q;
        end
    end

    assign nickel_req    = r_nickel_req;
    assign dime_req      = r_dime_req;
    assign dispense_item = r_dispense;
    assign busy          = !w_fifo_empty || (r_state != ST_IDLE);
    assign nickel_empty  = (r_nickel_inv == '0);
    assign dime_empty    = (r_dime_inv == '0);
    assign short_change  = r_short;
    assign overflow      = r_overflow;
    assign fault         = r_fault;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: payout timing, conversion, short change,
// overflow/timeout, vend pulse and asynchronous reset.
module tb_change_dispenser;
    import vending_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [2:0] change_in;
    logic       vend_in;
    logic       refill;
    logic       nickel_ack;
    logic       dime_ack;
    logic       nickel_req;
    logic       dime_req;
    logic       dispense_item;
    logic       busy;
    logic       nickel_empty;
    logic       dime_empty;
    logic       short_change;
    logic       overflow;
    logic       fault;

    int n_checks = 0;
    int n_errors = 0;

    // Hopper model state
    bit ack_en    = 1'b0;
    int ack_delay = 2;
    int n_acks    = 0;
    int d_acks    = 0;
    int n_wait    = 0;
    int d_wait    = 0;

    always #5 Clk = ~Clk;

    change_dispenser dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .change_in     (change_in),
        .vend_in       (vend_in),
        .refill        (refill),
        .nickel_ack    (nickel_ack),
        .dime_ack      (dime_ack),
        .nickel_req    (nickel_req),
        .dime_req      (dime_req),
        .dispense_item (dispense_item),
        .busy          (busy),
        .nickel_empty  (nickel_empty),
        .dime_empty    (dime_empty),
        .short_change  (short_change),
        .overflow      (overflow),
        .fault         (fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [2:0] code);
        change_in = code;
        tick();
        change_in = CODE_NONE;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (!busy) done = 1'b1;
        end
        check(tag, 32'(done), 1);
    endtask

    task automatic wait_req(input string tag, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (nickel_req) done = 1'b1;
        end
        check(tag, 32'(done), 1);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
        tick();
    endtask

    // Hopper responder: acks a held request ack_delay cycles after it rises.
    initial begin
        forever begin
            @(negedge Clk);
            if (ack_en) begin
                nickel_ack = 1'b0;
                dime_ack   = 1'b0;
                if (nickel_req) begin
                    n_wait++;
                    if (n_wait >= ack_delay) begin
                        nickel_ack = 1'b1;
                        n_wait     = 0;
                        n_acks++;
                    end
                end else begin
                    n_wait = 0;
                end
                if (dime_req) begin
                    d_wait++;
                    if (d_wait >= ack_delay) begin
                        dime_ack = 1'b1;
                        d_wait   = 0;
                        d_acks++;
                    end
                end else begin
                    d_wait = 0;
                end
            end else begin
                n_wait = 0;
                d_wait = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    logic [2:0] burst [5];
    int         pulses;

    initial begin
        Reset_n    = 1'b0;
        change_in  = CODE_NONE;
        vend_in    = 1'b0;
        refill     = 1'b0;
        nickel_ack = 1'b0;
        dime_ack   = 1'b0;
        tick();
        tick();
        check("rst_nickel_req", 32'(nickel_req), 0);
        check("rst_dime_req", 32'(dime_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_dispense", 32'(dispense_item), 0);
        check("rst_empty", 32'({nickel_empty, dime_empty}), 0);
        check("rst_flags", 32'({short_change, overflow, fault}), 0);
        Reset_n = 1'b1;
        tick();

        // Single nickel: req at t+3, wrong ack ignored, ack two cycles after req.
        send(NICKEL);
        tick();
        check("n1_req_t1", 32'(nickel_req), 0);
        tick();
        check("n1_req_t2", 32'(nickel_req), 0);
        tick();
        check("n1_req_t3", 32'(nickel_req), 1);
        check("n1_busy", 32'(busy), 1);
        dime_ack = 1'b1;
        tick();
        dime_ack = 1'b0;
        check("n1_wrong_ack", 32'(nickel_req), 1);
        check("n1_no_dime_req", 32'(dime_req), 0);
        nickel_ack = 1'b1;
        tick();
        nickel_ack = 1'b0;
        check("n1_req_drop", 32'(nickel_req), 0);
        check("n1_nickel_inv", 32'(dut.r_nickel_inv), 19);
        check("n1_dime_inv", 32'(dut.r_dime_inv), 20);
        tick();
        check("n1_busy_low", 32'(busy), 0);

        // Out-of-range code is ignored.
        send(QUARTER);
        check("quarter_ignored", 32'(busy), 0);
        tick();
        check("quarter_no_req", 32'({nickel_req, dime_req}), 0);

        // Vend level held 3 cycles yields one dispense pulse.
        pulses = 0;
        vend_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (dispense_item) pulses++;
        end
        vend_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (dispense_item) pulses++;
        end
        check("vend_pulses", 32'(pulses), 1);

        // Drain dimes, then code 100 must convert into four nickels.
        do_reset();
        ack_delay = 1;
        ack_en    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(DIMES_2);
            wait_idle("drain_dimes_idle", 40);
        end
        check("dimes_drained", 32'(dime_empty), 1);
        check("dime_acks_drain", 32'(d_acks), 20);
        n_acks = 0;
        d_acks = 0;
        send(DIMES_2);
        wait_idle("conv_idle", 60);
        check("conv_nickel_acks", 32'(n_acks), 4);
        check("conv_dime_acks", 32'(d_acks), 0);
        check("conv_nickel_inv", 32'(dut.r_nickel_inv), 16);
        check("conv_short", 32'(short_change), 0);

        // Drain nickels, then code 011 is unpayable.
        for (int i = 0; i < 16; i++) begin
            send(NICKEL);
            wait_idle("drain_nickels_idle", 20);
        end
        check("nickels_drained", 32'(nickel_empty), 1);
        n_acks = 0;
        d_acks = 0;
        send(NICKEL_DIME);
        wait_idle("short_idle", 6);
        check("short_flag", 32'(short_change), 1);
        check("short_no_coins", 32'(n_acks + d_acks), 0);
        check("short_no_fault", 32'(fault), 0);

        // Refill restores both inventories; short_change stays sticky.
        refill = 1'b1;
        tick();
        refill = 1'b0;
        check("refill_empty", 32'({nickel_empty, dime_empty}), 0);
        check("refill_nickel_inv", 32'(dut.r_nickel_inv), 20);
        check("refill_dime_inv", 32'(dut.r_dime_inv), 20);
        check("refill_short_sticky", 32'(short_change), 1);

        // Stalled hopper: fill FIFO behind a waiting nickel, overflow, timeout.
        ack_en = 1'b0;
        do_reset();
        send(NICKEL);
        wait_req("ovf_first_req", 8);
        burst[0] = DIME;
        burst[1] = NICKEL_DIME;
        burst[2] = DIMES_2;
        burst[3] = NICKEL;
        burst[4] = DIME;
        for (int i = 0; i < 5; i++) begin
            change_in = burst[i];
            tick();
            if (i == 3) check("ovf_after_4", 32'(overflow), 0);
            if (i == 4) check("ovf_after_5", 32'(overflow), 1);
        end
        change_in = CODE_NONE;
        repeat (10) tick();
        check("tmo_fault_early", 32'(fault), 0);
        check("tmo_req_held", 32'(nickel_req), 1);
        tick();
        check("tmo_fault", 32'(fault), 1);
        check("tmo_req_drop", 32'(nickel_req), 0);
        n_acks    = 0;
        d_acks    = 0;
        ack_delay = 2;
        ack_en    = 1'b1;
        wait_idle("resume_idle", 200);
        check("resume_nickel_acks", 32'(n_acks), 2);
        check("resume_dime_acks", 32'(d_acks), 4);
        check("resume_nickel_inv", 32'(dut.r_nickel_inv), 18);
        check("resume_dime_inv", 32'(dut.r_dime_inv), 16);
        check("resume_flags", 32'({short_change, overflow, fault}), 3'b011);

        // Asynchronous reset in the middle of a WAIT.
        ack_en = 1'b0;
        send(NICKEL);
        wait_req("arst_req", 8);
        tick();
        #2;
        Reset_n = 1'b0;
        #1;
        check("arst_req_drop", 32'(nickel_req), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_flags", 32'({short_change, overflow, fault}), 0);
        check("arst_nickel_inv", 32'(dut.r_nickel_inv), 20);
        check("arst_dime_inv", 32'(dut.r_dime_inv), 20);
        tick();
        Reset_n = 1'b1;
        tick();
        check("arst_idle_after", 32'({busy, nickel_req, dime_req}), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
